// File: rtl/add_share_arbiter.sv
// add_share_arbiter: shares one combinational signed adder between two
// requesters. Round-robin grant, registered operands, one operation in flight,
// tagged response on a single valid/ready channel.

// Combinational N-bit signed adder with an N+1-bit result that cannot overflow.
module add_n_bit_signed #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N:0]   o_sum
);

    // Sign-extend both operands by one bit so the sum always fits.
    always_comb begin
        o_sum = {i_a[N-1], i_a} + {i_b[N-1], i_b};
    end

endmodule

module add_share_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         req1_ready,
    output logic         resp_valid,
    output logic         resp_id,
    output logic [N:0]   resp_result,
    input  logic         resp_ready
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_state_d;

    logic         r_rr_ptr;
    logic         r_gnt;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic         r_resp_valid;
    logic         r_resp_id;
    logic [N:0]   r_resp_result;

    logic         w_any_req;
    logic         w_gnt;
    logic         w_accept;
    logic [N-1:0] w_sel_a;
    logic [N-1:0] w_sel_b;
    logic [N:0]   w_sum;

    // Grant selection: a lone request wins outright, a tie goes to rr_ptr.
    always_comb begin
        w_any_req = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_gnt = r_rr_ptr;
        end else begin
            w_gnt = req1_valid;
        end
        w_sel_a = w_gnt ? req1_a : req0_a;
        w_sel_b = w_gnt ? req1_b : req0_b;
    end

    // Ready is offered only in IDLE and only to the granted requester; it
    // depends on state and request inputs alone, never on resp_ready.
    always_comb begin
        w_accept   = (r_state == StIdle) && w_any_req && !rst;
        req0_ready = w_accept && !w_gnt;
        req1_ready = w_accept && w_gnt;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_d = StExec;
                end
            end
            StExec: begin
                w_state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Operand capture on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_gnt <= 1'b0;
        end else if (r_state == StIdle && w_any_req) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_gnt <= w_gnt;
        end
    end

    add_n_bit_signed #(
        .N (N)
    ) u_adder (
        .i_a   (r_a),
        .i_b   (r_b),
        .o_sum (w_sum)
    );

    // Response register and round-robin pointer update; the result and id are
    // held after consumption, only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_valid  <= 1'b0;
            r_resp_id     <= 1'b0;
            r_resp_result <= '0;
            r_rr_ptr      <= 1'b0;
        end else begin
            if (r_state == StExec) begin
                r_resp_valid  <= 1'b1;
                r_resp_id     <= r_gnt;
                r_resp_result <= w_sum;
                r_rr_ptr      <= ~r_gnt;
            end else if (r_state == StResp && resp_ready) begin
                r_resp_valid  <= 1'b0;
            end
        end
    end

    // Output drive from registers.
    always_comb begin
        resp_valid  = r_resp_valid;
        resp_id     = r_resp_id;
        resp_result = r_resp_result;
    end

endmodule
